// File: rtl/mac_vector.sv
// mac_vector: multi-lane signed dot-product MAC with bias, saturation and optional ReLU (MAC_VECTOR_RELU_EN)
module mac_vector #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16,
  parameter int LEN_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  data_in,
  input  logic [LANES*DATA_W-1:0]  weight_in,
  input  logic [LANES*DATA_W-1:0]  bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   result,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, HOLD} state_t;
  state_t state, state_nxt;
  logic [LEN_W-1:0] len_q, cnt, cnt_inc;
  logic [LANES*DATA_W-1:0] bias_q;
  logic signed [ACC_W-1:0] acc [LANES];
  logic signed [ACC_W-1:0] acc_add [LANES];
  logic signed [2*DATA_W-1:0] prod [LANES];
  logic [ACC_W:0] sum [LANES];
  logic [OUT_W-1:0] sat [LANES];
  logic [LANES*OUT_W-1:0] res_nxt;
  logic fire, last;
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  assign busy = state != IDLE;
  assign fire = in_valid & in_ready;
  assign cnt_inc = cnt + LEN_W'(1);
  assign last = fire && cnt_inc == len_q;
  // next-state decode; abort overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = start ? (len == '0 ? BIAS : ACCUM) : IDLE;
      ACCUM: state_nxt = last ? BIAS : ACCUM;
      BIAS:  state_nxt = HOLD;
      HOLD:  state_nxt = out_ready ? IDLE : HOLD;
    endcase
    if (abort) state_nxt = IDLE;
  end
  // per-lane product, accumulate, bias add with one guard bit, saturate and optional ReLU
  always_comb begin
    res_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = (2*DATA_W)'($signed(data_in[i*DATA_W +: DATA_W])) * (2*DATA_W)'($signed(weight_in[i*DATA_W +: DATA_W]));
      acc_add[i] = acc[i] + ACC_W'(prod[i]);
      sum[i] = (ACC_W+1)'(acc[i]) + (ACC_W+1)'($signed(bias_q[i*DATA_W +: DATA_W]));
      sat[i] = (&sum[i][ACC_W:OUT_W-1] | ~|sum[i][ACC_W:OUT_W-1]) ? sum[i][OUT_W-1:0] : {sum[i][ACC_W], {(OUT_W-1){~sum[i][ACC_W]}}};
`ifdef MAC_VECTOR_RELU_EN
      res_nxt[i*OUT_W +: OUT_W] = sat[i][OUT_W-1] ? '0 : sat[i];
`else
      res_nxt[i*OUT_W +: OUT_W] = sat[i];
`endif
    end
  end
  // state, beat counter, accumulators, latched operands and result register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      bias_q <= '0;
      result <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      state <= state_nxt;
      if (abort || (state == IDLE && start)) begin
        cnt <= '0;
        for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else if (fire) begin
        cnt <= cnt_inc;
        for (int i = 0; i < LANES; i++) acc[i] <= acc_add[i];
      end
      if (!abort && state == IDLE && start) begin
        len_q <= len;
        bias_q <= bias;
      end
      if (!abort && state == BIAS) result <= res_nxt;
    end
  end
endmodule

// File: tb/tb_mac_vector.sv
// tb_mac_vector: scoreboard bench for mac_vector with directed vectors
module tb_mac_vector;
  localparam int DATA_W = 8, LANES = 4, ACC_W = 24, OUT_W = 16, LEN_W = 8;
  logic clock = 0, reset_n = 0, start = 0, abort = 0, in_valid = 0, out_ready = 1;
  logic [LEN_W-1:0] len = '0;
  logic [LANES*DATA_W-1:0] data_in = '0, weight_in = '0, bias = '0;
  logic in_ready, out_valid, busy;
  logic [LANES*OUT_W-1:0] result;
  logic [LANES*OUT_W-1:0] exp_q[$];
  int n_pass = 0, n_total = 0;

  mac_vector #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .weight_in(weight_in),
    .bias(bias), .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, expv);
  endtask

  function automatic logic [31:0] p8(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [63:0] p16(input int a0, input int a1, input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  // monitor: every accepted result is compared against the oldest expectation
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", {63'b0, out_valid}, 64'd0);
      else chk("result", result, exp_q.pop_front());
    end
  end

  task automatic start_op(input logic [LEN_W-1:0] l, input logic [31:0] b);
    @(posedge clock); #1;
    start = 1; len = l; bias = b;
    @(posedge clock); #1;
    start = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [31:0] w);
    int t = 0;
    in_valid = 1; data_in = d; weight_in = w;
    @(negedge clock);
    while (!in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) chk("beat_timeout", {63'b0, in_ready}, 64'd1);
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 1000) begin
      @(negedge clock);
      t++;
    end
    chk("idle_timeout", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold_exp;
    #12;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    reset_n = 1;
    // basic dot product with latency check
    exp_q.push_back(p16(21, 3, -114, 30127));
    start_op(3, p8(1, 0, -2, 127));
    send_beat(p8(2, 1, -3, 100), p8(3, 1, 4, 100));
    send_beat(p8(4, 1, 0, 100), p8(5, 1, 9, 100));
    send_beat(p8(-1, 1, 10, 100), p8(6, 1, -10, 100));
    @(negedge clock);
    chk("lat_bias_cycle", {63'b0, out_valid}, 64'd0);
    @(negedge clock);
    chk("lat_hold_cycle", {63'b0, out_valid}, 64'd1);
    wait_idle();
    // zero-length: bias only, no beats consumed
    exp_q.push_back(p16(5, -7, 0, 127));
    start_op(0, p8(5, -7, 0, 127));
    @(negedge clock);
    chk("len0_no_ready", {63'b0, in_ready}, 64'd0);
    chk("len0_busy", {63'b0, busy}, 64'd1);
    wait_idle();
    // positive and negative saturation over 255 beats
    exp_q.push_back(p16(32767, 32767, 32767, 32767));
    start_op(255, '0);
    for (int k = 0; k < 255; k++) send_beat(p8(127, 127, 127, 127), p8(127, 127, 127, 127));
    wait_idle();
`ifdef MAC_VECTOR_RELU_EN
    exp_q.push_back(p16(0, 0, 0, 0));
`else
    exp_q.push_back(p16(-32768, -32768, -32768, -32768));
`endif
    start_op(255, '0);
    for (int k = 0; k < 255; k++) send_beat(p8(-128, -128, -128, -128), p8(127, 127, 127, 127));
    wait_idle();
    // back-pressure in HOLD with an ignored start pulse
    hold_exp = p16(1, 2, 3, 4);
    exp_q.push_back(hold_exp);
    out_ready = 0;
    start_op(1, '0);
    send_beat(p8(1, 2, 3, 4), p8(1, 1, 1, 1));
    @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("hold_valid", {63'b0, out_valid}, 64'd1);
      chk("hold_result", result, hold_exp);
      start = (k == 3);
      len = '0;
      bias = p8(9, 9, 9, 9);
    end
    start = 0;
    @(posedge clock); #1;
    out_ready = 1;
    wait_idle();
    // alternating in_valid: only four beats count
    exp_q.push_back(p16(16, 32, 48, 64));
    start_op(4, '0);
    for (int c = 0; c < 12; c++) begin
      in_valid = c[0];
      data_in = p8(c, c, c, c);
      weight_in = p8(1, 2, 3, 4);
      @(posedge clock); #1;
    end
    in_valid = 0;
    wait_idle();
    // abort during the second beat, then a clean run
    start_op(3, '0);
    send_beat(p8(1, 1, 1, 1), p8(1, 1, 1, 1));
    in_valid = 1;
    abort = 1;
    @(posedge clock); #1;
    abort = 0;
    in_valid = 0;
    @(negedge clock);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_in_ready", {63'b0, in_ready}, 64'd0);
    repeat (5) @(negedge clock);
    chk("abort_no_valid", {63'b0, out_valid}, 64'd0);
    exp_q.push_back(p16(5, 5, 5, 5));
    start_op(1, p8(1, 1, 1, 1));
    send_beat(p8(2, 2, 2, 2), p8(2, 2, 2, 2));
    wait_idle();
    // reset during the second beat, then a clean run
    start_op(3, '0);
    send_beat(p8(1, 1, 1, 1), p8(1, 1, 1, 1));
    in_valid = 1;
    @(negedge clock);
    reset_n = 0;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_result", result, 64'd0);
    in_valid = 0;
    @(posedge clock); #1;
    reset_n = 1;
    repeat (5) @(negedge clock);
    chk("arst_no_valid", {63'b0, out_valid}, 64'd0);
    exp_q.push_back(p16(5, 5, 5, 5));
    start_op(1, p8(1, 1, 1, 1));
    send_beat(p8(2, 2, 2, 2), p8(2, 2, 2, 2));
    wait_idle();
    repeat (5) @(negedge clock);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
